// File: rtl/m2_block_writer.sv
// m2_block_writer: drains one 8x8 block of signed 32-bit IDCT results from the
// dual-port result RAM, clips each value to 8 bits, packs pixel pairs and writes
// the 32 words of the block into the Y, U or V plane of external SRAM.
module m2_block_writer #(
  parameter logic [17:0] Y_BASE = 18'd0,
  parameter logic [17:0] U_BASE = 18'd38400,
  parameter logic [17:0] V_BASE = 18'd57600
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        wr_start,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  input  logic [1:0]  plane,
  output logic [6:0]  dp_address_a,
  output logic [6:0]  dp_address_b,
  input  logic [31:0] dp_read_data_a,
  input  logic [31:0] dp_read_data_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        wr_busy,
  output logic        wr_done
);

  typedef enum logic [1:0] {StIdle, StLead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  // Word index whose RAM data is on the read ports during StWrite.
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [1:0]  plane_q, plane_d;
  logic [6:0]  dp_a_d, dp_b_d;
  logic [17:0] addr_d;
  logic [15:0] wdata_d;
  logic        we_n_d, busy_d, done_d;

  logic [17:0] line, line_words, base, word_addr;

  // Signed value to 0..255.
  function automatic logic [7:0] clip8(input logic [31:0] v);
    if (v[31]) begin
      return 8'h00;
    end else if (|v[30:8]) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

  // SRAM word address of word cnt_q; plane widths built from shifts.
  always_comb begin
    line = 18'({row_q, 3'b000}) + 18'(cnt_q[4:2]);
    if (plane_q == 2'd0) begin
      line_words = (line << 7) + (line << 5);
      base       = Y_BASE;
    end else begin
      line_words = (line << 6) + (line << 4);
      base       = (plane_q == 2'd1) ? U_BASE : V_BASE;
    end
    word_addr = base + line_words + 18'({col_q, 2'b00}) + 18'(cnt_q[1:0]);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    plane_d = plane_q;
    dp_a_d  = dp_address_a;
    dp_b_d  = dp_address_b;
    addr_d  = SRAM_address;
    wdata_d = SRAM_write_data;
    we_n_d  = 1'b1;
    busy_d  = wr_busy;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (wr_start) begin
          row_d   = block_row;
          col_d   = block_col;
          plane_d = plane;
          busy_d  = 1'b1;
          dp_a_d  = 7'd0;
          dp_b_d  = 7'd1;
          state_d = StLead;
        end
      end
      StLead: begin
        dp_a_d  = 7'd2;
        dp_b_d  = 7'd3;
        cnt_d   = 5'd0;
        state_d = StWrite;
      end
      StWrite: begin
        we_n_d  = 1'b0;
        addr_d  = word_addr;
        wdata_d = {clip8(dp_read_data_a), clip8(dp_read_data_b)};
        // Reads run two words ahead of the write being registered.
        if (cnt_q < 5'd30) begin
          dp_a_d = {1'b0, cnt_q + 5'd2, 1'b0};
          dp_b_d = {1'b0, cnt_q + 5'd2, 1'b1};
        end else begin
          dp_a_d = 7'd0;
          dp_b_d = 7'd0;
        end
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone: begin
        addr_d  = 18'd0;
        wdata_d = 16'd0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset forces SRAM_we_n high asynchronously.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      cnt_q           <= 5'd0;
      row_q           <= 5'd0;
      col_q           <= 6'd0;
      plane_q         <= 2'd0;
      dp_address_a    <= 7'd0;
      dp_address_b    <= 7'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      wr_busy         <= 1'b0;
      wr_done         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      row_q           <= row_d;
      col_q           <= col_d;
      plane_q         <= plane_d;
      dp_address_a    <= dp_a_d;
      dp_address_b    <= dp_b_d;
      SRAM_address    <= addr_d;
      SRAM_write_data <= wdata_d;
      SRAM_we_n       <= we_n_d;
      wr_busy         <= busy_d;
      wr_done         <= done_d;
    end
  end

endmodule
